// File: rtl/recip_arbiter.sv
// recip_arbiter: round-robin arbiter in front of a single shared reciprocal unit.
// One transaction in flight at a time; zero-mantissa divisors are answered
// locally with a saturated result and a one-cycle div_zero pulse.
module recip_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MANTISSA_W = 16,
  parameter int unsigned EXP_W      = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_REQ*(MANTISSA_W+EXP_W)-1:0]       req_data,
  input  logic [N_REQ-1:0]                          req_valid,
  output logic [N_REQ-1:0]                          req_ready,
  output logic [MANTISSA_W+EXP_W-1:0]               rsp_data,
  output logic [N_REQ-1:0]                          rsp_valid,
  input  logic [N_REQ-1:0]                          rsp_ready,
  output logic                                      div_zero,
  output logic                                      busy,
  output logic [$clog2(N_REQ)-1:0]                  owner,
  output logic [MANTISSA_W+EXP_W-1:0]               div_d,
  output logic                                      div_in_valid,
  input  logic                                      div_in_ready,
  input  logic [MANTISSA_W+EXP_W-1:0]               div_out,
  input  logic                                      div_out_valid,
  output logic                                      div_out_ready
);

  localparam int unsigned W  = MANTISSA_W + EXP_W;
  localparam int unsigned OW = $clog2(N_REQ);

  typedef struct packed {
    logic [MANTISSA_W-1:0] mant;
    logic [EXP_W-1:0]      expo;
  } word_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  // Largest positive mantissa and exponent: the saturated reciprocal of zero.
  localparam word_t SAT_WORD = {1'b0, {(MANTISSA_W-1){1'b1}}, 1'b0, {(EXP_W-1){1'b1}}};

  state_t          r_state;
  state_t          w_next;
  word_t           r_operand;
  word_t           r_result;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last;
  logic            r_div_zero;

  logic            w_found;
  logic [OW-1:0]   w_gidx;
  word_t           w_req_word;
  logic            w_req_zero;
  logic            w_accept;
  logic            w_capture;
  logic            w_rsp_done;

  // Index of the requester examined at search position offs after base.
  function automatic logic [OW-1:0] rr_index(input logic [OW-1:0] base,
                                             input int unsigned   offs);
    int unsigned sum;
    sum = 32'(base) + 32'd1 + offs;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    return OW'(sum);
  endfunction

  // Round-robin search starting just after the last served requester.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[rr_index(r_last, i)]) begin
        w_found = 1'b1;
        w_gidx  = rr_index(r_last, i);
      end
    end
  end

  assign w_req_word = word_t'(req_data[32'(w_gidx)*W +: W]);
  assign w_req_zero = (w_req_word.mant == '0);
  assign w_accept   = (r_state == S_IDLE) && w_found && !rst;

  // Same-cycle one-hot accept strobe for the winning requester.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_gidx] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_next        = r_state;
    busy          = 1'b1;
    div_in_valid  = 1'b0;
    div_out_ready = 1'b0;
    rsp_valid     = '0;
    w_capture     = 1'b0;
    w_rsp_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_next = w_req_zero ? S_RETURN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_in_valid = 1'b1;
        if (div_in_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        div_out_ready = 1'b1;
        if (div_out_valid) begin
          w_capture = 1'b1;
          w_next    = S_RETURN;
        end
      end
      S_RETURN: begin
        rsp_valid[r_owner] = 1'b1;
        if (rsp_ready[r_owner]) begin
          w_rsp_done = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand/result/ownership registers and the zero-divisor pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_operand  <= '0;
      r_result   <= '0;
      r_owner    <= '0;
      r_last     <= OW'(N_REQ - 1);
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= 1'b0;
      if (w_accept) begin
        r_operand <= w_req_word;
        r_owner   <= w_gidx;
        if (w_req_zero) begin
          r_result   <= SAT_WORD;
          r_div_zero <= 1'b1;
        end
      end
      if (w_capture) begin
        r_result <= word_t'(div_out);
      end
      if (w_rsp_done) begin
        r_last <= r_owner;
      end
    end
  end

  assign div_d    = r_operand;
  assign rsp_data = r_result;
  assign owner    = r_owner;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_recip_arbiter.sv
// tb_recip_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level round-robin model; the reciprocal unit is a latency model
// returning operand ^ 0xFFFF00.
module tb_recip_arbiter;

  localparam int N   = 4;
  localparam int MW  = 16;
  localparam int EW  = 8;
  localparam int W   = MW + EW;
  localparam int OWW = $clog2(N);
  localparam logic [W-1:0] XMASK = 24'hFFFF00;
  localparam logic [W-1:0] SATW  = 24'h7FFF7F;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_data, div_d;
  logic [W-1:0]   div_out = '0;
  logic           div_out_valid = 1'b0;
  logic           div_zero, busy, div_in_valid, div_in_ready, div_out_ready;
  logic [OWW-1:0] owner;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int lat     = 6;

  logic         u_pend = 1'b0;
  int           u_cnt  = 0;
  logic [W-1:0] u_op   = '0;

  always #5 clk = ~clk;

  recip_arbiter #(.N_REQ(N), .MANTISSA_W(MW), .EXP_W(EW)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .div_zero(div_zero), .busy(busy), .owner(owner),
    .div_d(div_d), .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
    .div_out(div_out), .div_out_valid(div_out_valid), .div_out_ready(div_out_ready)
  );

  // Reciprocal unit model: result visible L-1 edges after the input transfer edge.
  always @(posedge clk) begin
    if (rst) begin
      u_pend        <= 1'b0;
      u_cnt         <= 0;
      div_out_valid <= 1'b0;
    end else begin
      if (div_out_valid && div_out_ready) div_out_valid <= 1'b0;
      if (div_in_valid && div_in_ready) begin
        if (lat <= 1) begin
          div_out_valid <= 1'b1;
          div_out       <= div_d ^ XMASK;
        end else begin
          u_pend <= 1'b1;
          u_cnt  <= lat - 1;
          u_op   <= div_d;
        end
      end else if (u_pend) begin
        if (u_cnt <= 1) begin
          u_pend        <= 1'b0;
          div_out_valid <= 1'b1;
          div_out       <= u_op ^ XMASK;
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    int k;
    for (int i = 1; i <= N; i++) begin
      k = (last + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_nz();
    logic [W-1:0] w;
    w = {16'($urandom_range(1, 16'hFFFF)), 8'($urandom)};
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
    cyc_n++;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '0;
    rsp_ready    = '0;
    div_in_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Offers vmask, waits for the grant and the response (rsp_ready all ones).
  task automatic run_txn(input logic [N-1:0] vmask, input bit drop,
                         output int gidx, output logic [W-1:0] rdata,
                         output int t_acc, output int t_rsp, output bit tmo);
    gidx = -1; rdata = '0; t_acc = 0; t_rsp = 0; tmo = 1'b1;
    req_valid = vmask;
    rsp_ready = '1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready != '0) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) gidx = k;
        t_acc = cyc_n;
        tmo   = 1'b0;
        break;
      end
      cyc();
    end
    if (!tmo) begin
      cyc();
      if (drop) req_valid[gidx] = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < 200; i++) begin
        #1;
        if (rsp_valid != '0) begin
          rdata = rsp_data;
          t_rsp = cyc_n;
          tmo   = 1'b0;
          break;
        end
        cyc();
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    req_valid    = '1;
    req_data     = {N{rand_nz()}};
    rsp_ready    = '1;
    div_in_ready = 1'b1;
    cyc();
    cyc();
    #1;
    n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
    n_tests++; if (owner !== '0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_tests++; if (div_d !== '0) begin n_fail++; $display("FAIL reset_div_d: got %h want 0", div_d); end
    n_tests++; if (div_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_div_in_valid: got %b want 0", div_in_valid); end
    n_tests++; if (div_out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_div_out_ready: got %b want 0", div_out_ready); end
    rst       = 1'b0;
    req_valid = '0;
    cyc();
  endtask

  task automatic test_single();
    bit early;
    do_reset();
    lat = 6;
    req_data = {rand_nz(), 24'h400003, rand_nz(), rand_nz()};
    req_valid = 4'b0100;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    early = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      req_valid = '0;
      if (c == 8) rsp_ready = 4'b0100;
      #1;
      if (c == 1) begin
        n_tests++; if (div_in_valid !== 1'b1 || div_d !== 24'h400003) begin n_fail++; $display("FAIL single_issue: got v=%b d=%h want v=1 d=400003", div_in_valid, div_d); end
      end
      if (c < 8 && rsp_valid !== '0) early = 1'b1;
    end
    n_tests++; if (early) begin n_fail++; $display("FAIL single_early_rsp: got early rsp_valid want none before cycle 8"); end
    n_tests++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
    n_tests++; if (rsp_data !== 24'hBFFF03) begin n_fail++; $display("FAIL single_rsp_data: got %h want bfff03", rsp_data); end
    cyc();
    rsp_ready = '0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int gidx, t_acc, t_rsp, prev_acc, m_last, exp_k;
    logic [W-1:0] rdata;
    bit tmo;
    do_reset();
    lat = 4;
    for (int k = 0; k < N; k++) req_data[k*W +: W] = rand_nz();
    m_last = N - 1;
    prev_acc = 0;
    for (int n = 0; n < 5; n++) begin
      run_txn(4'b1111, 1'b0, gidx, rdata, t_acc, t_rsp, tmo);
      exp_k = rr_pick(m_last, 4'b1111);
      n_tests++; if (tmo) begin n_fail++; $display("FAIL rr_timeout: got timeout want grant %0d", exp_k); end
      if (!tmo) begin
        n_tests++; if (gidx != exp_k) begin n_fail++; $display("FAIL rr_order: got %0d want %0d", gidx, exp_k); end
        n_tests++; if (rdata !== (req_data[exp_k*W +: W] ^ XMASK)) begin n_fail++; $display("FAIL rr_data: got %h want %h", rdata, req_data[exp_k*W +: W] ^ XMASK); end
        n_tests++; if (t_rsp - t_acc != lat + 2) begin n_fail++; $display("FAIL rr_latency: got %0d want %0d", t_rsp - t_acc, lat + 2); end
        if (n > 0) begin
          n_tests++; if (t_acc - prev_acc != lat + 3) begin n_fail++; $display("FAIL rr_spacing: got %0d want %0d", t_acc - prev_acc, lat + 3); end
        end
      end
      prev_acc = t_acc;
      m_last   = exp_k;
    end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    int gidx, t_acc, t_rsp, m_last, exp_k;
    logic [W-1:0] rdata;
    bit tmo;
    logic [N-1:0] masks [3];
    do_reset();
    lat = 2;
    for (int k = 0; k < N; k++) req_data[k*W +: W] = rand_nz();
    masks[0] = 4'b0010; masks[1] = 4'b1001; masks[2] = 4'b1001;
    m_last = N - 1;
    for (int n = 0; n < 3; n++) begin
      run_txn(masks[n], 1'b1, gidx, rdata, t_acc, t_rsp, tmo);
      exp_k = rr_pick(m_last, masks[n]);
      n_tests++; if (tmo || gidx != exp_k) begin n_fail++; $display("FAIL fair_grant%0d: got %0d want %0d", n, gidx, exp_k); end
      m_last = exp_k;
    end
    req_valid = '0;
  endtask

  task automatic test_zero_bypass();
    bit saw_issue;
    do_reset();
    lat = 3;
    req_data = {rand_nz(), 24'h000005, rand_nz(), rand_nz()};
    req_valid = 4'b0100;
    rsp_ready = '0;
    #1;
    saw_issue = div_in_valid;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL zero_grant: got %b want 0100", req_ready); end
    cyc();
    req_valid = '0;
    #1;
    saw_issue |= div_in_valid;
    n_tests++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL zero_pulse: got %b want 1", div_zero); end
    n_tests++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL zero_rsp_valid: got %b want 0100", rsp_valid); end
    n_tests++; if (rsp_data !== SATW) begin n_fail++; $display("FAIL zero_rsp_data: got %h want %h", rsp_data, SATW); end
    n_tests++; if (owner !== 2'd2) begin n_fail++; $display("FAIL zero_owner: got %0d want 2", owner); end
    cyc();
    #1;
    saw_issue |= div_in_valid;
    n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_len: got %b want 0", div_zero); end
    n_tests++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL zero_rsp_hold: got %b want 0100", rsp_valid); end
    rsp_ready = 4'b0100;
    cyc();
    #1;
    saw_issue |= div_in_valid;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got busy=%b want 0", busy); end
    n_tests++; if (saw_issue) begin n_fail++; $display("FAIL zero_no_issue: got div_in_valid=1 want never"); end
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    bit tmo;
    do_reset();
    lat = 3;
    d = rand_nz();
    req_data = {rand_nz(), rand_nz(), d, rand_nz()};
    div_in_ready = 1'b0;
    req_valid = 4'b0010;
    rsp_ready = '0;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    cyc();
    req_valid = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (div_in_valid !== 1'b1) begin n_fail++; $display("FAIL bp_in_valid: got %b want 1", div_in_valid); end
      n_tests++; if (div_d !== d) begin n_fail++; $display("FAIL bp_div_d: got %h want %h", div_d, d); end
      n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_req_ready: got %b want 0", req_ready); end
      cyc();
    end
    div_in_ready = 1'b1;
    tmo = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (rsp_valid != '0) begin tmo = 1'b0; break; end
      cyc();
    end
    n_tests++; if (tmo) begin n_fail++; $display("FAIL bp_rsp_timeout: got none want rsp_valid"); end
    rsp_ready = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_rsp_valid: got %b want 0010", rsp_valid); end
      n_tests++; if (rsp_data !== (d ^ XMASK)) begin n_fail++; $display("FAIL bp_rsp_data: got %h want %h", rsp_data, d ^ XMASK); end
      n_tests++; if (req_ready !== '0 || div_d !== d) begin n_fail++; $display("FAIL bp_hold: got rdy=%b d=%h want rdy=0 d=%h", req_ready, div_d, d); end
      cyc();
      #1;
    end
    rsp_ready = 4'b0010;
    cyc();
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
    req_valid = '0;
    rsp_ready = '0;
  endtask

  task automatic test_reset_in_wait();
    logic [W-1:0] d0;
    bit tmo;
    do_reset();
    lat = 20;
    d0 = rand_nz();
    req_data = {rand_nz(), rand_nz(), rand_nz(), d0};
    req_valid = 4'b1000;
    rsp_ready = '0;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rw_grant: got %b want 1000", req_ready); end
    cyc();
    req_valid = '0;
    tmo = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (div_out_ready) begin tmo = 1'b0; break; end
      cyc();
    end
    n_tests++; if (tmo) begin n_fail++; $display("FAIL rw_wait_timeout: got no div_out_ready want 1"); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy: got %b want 0", busy); end
    n_tests++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL rw_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (div_out_ready !== 1'b0) begin n_fail++; $display("FAIL rw_out_ready: got %b want 0", div_out_ready); end
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rw_regrant: got %b want 0001", req_ready); end
    rsp_ready = '1;
    cyc();
    req_valid = '0;
    tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rsp_valid != '0) begin tmo = 1'b0; break; end
      cyc();
    end
    n_tests++; if (tmo || rsp_valid !== 4'b0001 || rsp_data !== (d0 ^ XMASK)) begin n_fail++; $display("FAIL rw_rsp: got v=%b d=%h want v=0001 d=%h", rsp_valid, rsp_data, d0 ^ XMASK); end
    cyc();
    rsp_ready = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [W-1:0] w, m_exp;
    int m_last, m_owner, exp_k, done;
    bit m_busy, m_zero_next;
    do_reset();
    pend = '0; m_last = N - 1; m_owner = 0; m_busy = 1'b0; m_zero_next = 1'b0; done = 0; m_exp = '0;
    for (int c = 0; c < 6000 && done < 120; c++) begin
      if (!m_busy) lat = $urandom_range(1, 5);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom % 4 == 0)) begin
          pend[k] = 1'b1;
          w = W'($urandom);
          if ($urandom % 6 == 0) w[W-1:EW] = '0;
          req_data[k*W +: W] = w;
        end else if (pend[k] && ($urandom % 32 == 0)) begin
          pend[k] = 1'b0;
        end
      end
      req_valid    = pend;
      rsp_ready    = N'($urandom);
      div_in_ready = ($urandom % 3 != 0);
      #1;
      n_tests++; if (div_zero !== m_zero_next) begin n_fail++; $display("FAIL rnd_div_zero: got %b want %b at cycle %0d", div_zero, m_zero_next, cyc_n); end
      m_zero_next = 1'b0;
      if (!m_busy) begin
        exp_k = rr_pick(m_last, req_valid);
        n_tests++; if (req_ready !== ((exp_k >= 0) ? oh(exp_k) : '0)) begin n_fail++; $display("FAIL rnd_grant: got %b want %b at cycle %0d", req_ready, (exp_k >= 0) ? oh(exp_k) : '0, cyc_n); end
        n_tests++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL rnd_idle_rsp: got %b want 0 at cycle %0d", rsp_valid, cyc_n); end
        if (exp_k >= 0) begin
          m_busy  = 1'b1;
          m_owner = exp_k;
          w       = req_data[exp_k*W +: W];
          if (w[W-1:EW] == '0) begin
            m_exp = SATW;
            m_zero_next = 1'b1;
          end else begin
            m_exp = w ^ XMASK;
          end
          pend[exp_k] = 1'b0;
        end
      end else begin
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL rnd_busy_ready: got %b want 0 at cycle %0d", req_ready, cyc_n); end
        n_tests++; if (owner !== OWW'(m_owner)) begin n_fail++; $display("FAIL rnd_owner: got %0d want %0d at cycle %0d", owner, m_owner, cyc_n); end
        if (rsp_valid != '0) begin
          n_tests++; if (rsp_valid !== oh(m_owner)) begin n_fail++; $display("FAIL rnd_rsp_valid: got %b want %b at cycle %0d", rsp_valid, oh(m_owner), cyc_n); end
          n_tests++; if (rsp_data !== m_exp) begin n_fail++; $display("FAIL rnd_rsp_data: got %h want %h at cycle %0d", rsp_data, m_exp, cyc_n); end
          if (rsp_ready[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
            done++;
          end
        end
      end
      cyc();
    end
    n_tests++; if (done < 120) begin n_fail++; $display("FAIL rnd_progress: got %0d completions want 120", done); end
    req_valid = '0;
    rsp_ready = '0;
  endtask

  initial begin
    rst          = 1'b1;
    req_data     = '0;
    req_valid    = '0;
    rsp_ready    = '0;
    div_in_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_zero_bypass();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
